operand_sequencer: RTL and testbench
====================================

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter: WIDTH, 16, operand/result data width.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: req_valid  in  1  operation request present.
REQ-005 Port: req_ready  out  1  sequencer idle; request accepted when req_valid&req_ready.
REQ-006 Port: req_a_sel / req_b_sel / req_dst_sel  in  4 each  source A, source B and destination register selectors.
REQ-007 Port: req_use_b  in  1  operand B required; req_wr_back  in  1  result written to req_dst_sel.
REQ-008 Port: rf_a_sel, rf_b_sel  out  4  register-file port selectors.
REQ-009 Port: rf_a_rd_en, rf_b_rd_en, rf_a_wr_en  out  1  register-file read/pop and write/push strobes.
REQ-010 Port: rf_a_wr_data  out  WIDTH  write/push data; rf_a_rd_data, rf_b_rd_data  in  WIDTH  register-file read data.
REQ-011 Port: ex_valid  out  1, ex_ready  in  1, ex_a, ex_b  out  WIDTH  operand handoff to execute stage.
REQ-012 Port: ex_result_valid  in  1, ex_result  in  WIDTH  result return from execute stage.

Function
REQ-013 Selectors 4'hF (parameter stack) and 4'hE (return stack) are stack registers; 0-13 are general registers.
REQ-014 General-register read: data valid on rf_*_rd_data the cycle after rd_en, held while rd_en low; stack read: pop data valid in the same cycle the pop strobe is high.
REQ-015 States: IDLE, READ, READ_B2, LATCH, ISSUE, WAIT, WRITE; one operation outstanding at a time.
REQ-016 IDLE: req_ready=1; on accept, latch all req_* fields and go READ; otherwise stay.
REQ-017 READ: rf_a_sel=a, rf_a_rd_en=1; if use_b and no conflict, also rf_b_sel=b, rf_b_rd_en=1; stack-sourced operands captured this cycle.
REQ-018 Conflict: use_b=1 and a_sel==b_sel with both in {E,F}; READ then pops A only and next state is READ_B2, else LATCH.
REQ-019 READ_B2: rf_b_sel=b, rf_b_rd_en=1, B captured from rf_b_rd_data; next LATCH (A=old top, B=next element).
REQ-020 LATCH: no strobes; general-sourced operands captured from rf_*_rd_data; next ISSUE.
REQ-021 ex_b=0 whenever use_b=0; B port strobes never asserted when use_b=0.
REQ-022 ISSUE: ex_valid=1, ex_a/ex_b stable; on ex_ready go WAIT, else hold.
REQ-023 WAIT: on ex_result_valid latch ex_result; go WRITE if wr_back else IDLE; ex_result_valid ignored in all other states.
REQ-024 WRITE: rf_a_sel=dst, rf_a_wr_en=1, rf_a_wr_data=result for exactly one cycle, rd strobes low; next IDLE.
REQ-025 Never assert rf_a_wr_en and rf_a_rd_en in the same cycle; every strobe asserts for exactly one cycle per access (exactly one pop per stack operand).
REQ-026 Latency: accept at end of cycle 0 -> ex_valid in cycle 3 (cycle 4 with conflict); same-cycle result -> write cycle follows WAIT.
REQ-027 Selectors and write data driven to 0 in states that use no strobe.

Reset
REQ-028 reset (any state, mid-operation included) -> IDLE next cycle; req_ready=1; ex_valid, all rf strobes=0; ex_a, ex_b, latched result, selectors=0; in-flight operation discarded with no write.

Verification
REQ-029 R3=0x1234, R5=0x00FF, a=3,b=5,use_b=1,ex_ready=1 -> ex_valid cycle 3 with ex_a=0x1234, ex_b=0x00FF; one rd_en each port.
REQ-030 Param stack top 0xAAAA over 0xBBBB, a=b=F, use_b=1 -> two single-cycle pops on separate cycles, ex_a=0xAAAA, ex_b=0xBBBB, ex_valid cycle 4.
REQ-031 a=F, b=2 (R2=0x0042), use_b=1 -> no conflict, pop and R2 read same cycle, ex_a=top, ex_b=0x0042.
REQ-032 ex_ready low 5 cycles -> ex_valid/ex_a/ex_b held; result 0x5555, wr_back=1, dst=E -> one-cycle push of 0x5555, then req_ready=1.
REQ-033 reset asserted in ISSUE and again in WRITE -> no rf_a_wr_en, all outputs zero, next request processes normally.
REQ-034 use_b=0, wr_back=0 -> no B strobes, ex_b=0, return to IDLE right after ex_result_valid with no write.

Source files
------------

// File: rtl/operand_sequencer.sv
// Operand sequencer: fetches up to two operands from a register file with stack
// registers, hands them to an execute stage and optionally writes the result back.
module operand_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    // Handshake (req and ex): a transfer happens on a rising edge where valid and
    // ready are both high; valid holds its payload stable until that edge.
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_a_sel,
    input  logic [3:0]       req_b_sel,
    input  logic [3:0]       req_dst_sel,
    input  logic             req_use_b,
    input  logic             req_wr_back,
    output logic [3:0]       rf_a_sel,
    output logic [3:0]       rf_b_sel,
    output logic             rf_a_rd_en,
    output logic             rf_b_rd_en,
    output logic             rf_a_wr_en,
    output logic [WIDTH-1:0] rf_a_wr_data,
    input  logic [WIDTH-1:0] rf_a_rd_data,
    input  logic [WIDTH-1:0] rf_b_rd_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    input  logic             ex_result_valid,
    input  logic [WIDTH-1:0] ex_result,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_READ_B2 = 3'd2,
        S_LATCH   = 3'd3,
        S_ISSUE   = 3'd4,
        S_WAIT    = 3'd5,
        S_WRITE   = 3'd6
    } state_t;

    state_t     state;
    logic [3:0] a_sel;
    logic [3:0] b_sel;
    logic [3:0] dst_sel;
    logic       use_b;
    logic       wr_back;
    logic       conflict;
    logic       wr_en_q;
    logic       req_conflict;

    function automatic logic is_stack(input logic [3:0] sel);
        return sel[3:1] == 3'b111;
    endfunction

    // Both operands popping the same stack must pop on separate cycles.
    assign req_conflict = req_use_b && (req_a_sel == req_b_sel) && is_stack(req_a_sel);

    // A write still pending when reset arrives is dropped immediately.
    assign rf_a_wr_en = wr_en_q & ~reset;
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            req_ready    <= 1'b1;
            a_sel        <= 4'h0;
            b_sel        <= 4'h0;
            dst_sel      <= 4'h0;
            use_b        <= 1'b0;
            wr_back      <= 1'b0;
            conflict     <= 1'b0;
            rf_a_sel     <= 4'h0;
            rf_b_sel     <= 4'h0;
            rf_a_rd_en   <= 1'b0;
            rf_b_rd_en   <= 1'b0;
            wr_en_q      <= 1'b0;
            rf_a_wr_data <= '0;
            ex_valid     <= 1'b0;
            ex_a         <= '0;
            ex_b         <= '0;
        end else begin
            rf_a_sel     <= 4'h0;
            rf_b_sel     <= 4'h0;
            rf_a_rd_en   <= 1'b0;
            rf_b_rd_en   <= 1'b0;
            wr_en_q      <= 1'b0;
            rf_a_wr_data <= '0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        a_sel      <= req_a_sel;
                        b_sel      <= req_b_sel;
                        dst_sel    <= req_dst_sel;
                        use_b      <= req_use_b;
                        wr_back    <= req_wr_back;
                        conflict   <= req_conflict;
                        ex_a       <= '0;
                        ex_b       <= '0;
                        req_ready  <= 1'b0;
                        rf_a_sel   <= req_a_sel;
                        rf_a_rd_en <= 1'b1;
                        if (req_use_b && !req_conflict) begin
                            rf_b_sel   <= req_b_sel;
                            rf_b_rd_en <= 1'b1;
                        end
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    // Stack pops deliver data in the strobe cycle itself.
                    if (is_stack(a_sel)) ex_a <= rf_a_rd_data;
                    if (use_b && !conflict && is_stack(b_sel)) ex_b <= rf_b_rd_data;
                    if (conflict) begin
                        rf_b_sel   <= b_sel;
                        rf_b_rd_en <= 1'b1;
                        state      <= S_READ_B2;
                    end else begin
                        state <= S_LATCH;
                    end
                end
                S_READ_B2: begin
                    ex_b  <= rf_b_rd_data;
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    if (!is_stack(a_sel)) ex_a <= rf_a_rd_data;
                    if (use_b && !is_stack(b_sel)) ex_b <= rf_b_rd_data;
                    ex_valid <= 1'b1;
                    state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (ex_ready) begin
                        ex_valid <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ex_result_valid) begin
                        if (wr_back) begin
                            rf_a_sel     <= dst_sel;
                            wr_en_q      <= 1'b1;
                            rf_a_wr_data <= ex_result;
                            state        <= S_WRITE;
                        end else begin
                            req_ready <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_WRITE: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a register-file/stack model and
// hand-computed expectations.
module tb_operand_sequencer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready;
    logic [3:0]   req_a_sel, req_b_sel, req_dst_sel;
    logic         req_use_b, req_wr_back;
    logic [3:0]   rf_a_sel, rf_b_sel;
    logic         rf_a_rd_en, rf_b_rd_en, rf_a_wr_en;
    logic [W-1:0] rf_a_wr_data, rf_a_rd_data, rf_b_rd_data;
    logic         ex_valid, ex_ready;
    logic [W-1:0] ex_a, ex_b;
    logic         ex_result_valid;
    logic [W-1:0] ex_result;
    logic [2:0]   state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a_sel(req_a_sel), .req_b_sel(req_b_sel), .req_dst_sel(req_dst_sel),
        .req_use_b(req_use_b), .req_wr_back(req_wr_back),
        .rf_a_sel(rf_a_sel), .rf_b_sel(rf_b_sel),
        .rf_a_rd_en(rf_a_rd_en), .rf_b_rd_en(rf_b_rd_en), .rf_a_wr_en(rf_a_wr_en),
        .rf_a_wr_data(rf_a_wr_data), .rf_a_rd_data(rf_a_rd_data), .rf_b_rd_data(rf_b_rd_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b),
        .ex_result_valid(ex_result_valid), .ex_result(ex_result),
        .state_dbg(state_dbg)
    );

    // Register file model: general regs read with one cycle latency, stacks pop combinationally.
    logic [W-1:0] regs [0:15] = '{default: '0};
    logic [W-1:0] stk0 [0:7]  = '{default: '0};
    logic [W-1:0] stk1 [0:7]  = '{default: '0};
    logic [2:0]   sp0 = 3'd0, sp1 = 3'd0;
    logic [W-1:0] a_hold = '0, b_hold = '0;
    logic         pl_en = 1'b0;
    logic [3:0]   pl_sel = 4'h0;
    logic [W-1:0] pl_data = '0;
    int a_rd_cnt = 0, b_rd_cnt = 0, wr_cnt = 0, overlap_cnt = 0;

    assign rf_a_rd_data = (rf_a_rd_en && rf_a_sel == 4'hF) ? stk0[sp0 - 3'd1] :
                          (rf_a_rd_en && rf_a_sel == 4'hE) ? stk1[sp1 - 3'd1] : a_hold;
    assign rf_b_rd_data = (rf_b_rd_en && rf_b_sel == 4'hF) ? stk0[sp0 - 3'd1] :
                          (rf_b_rd_en && rf_b_sel == 4'hE) ? stk1[sp1 - 3'd1] : b_hold;

    always @(posedge clk) begin
        if (pl_en) begin
            if (pl_sel == 4'hF) begin
                stk0[sp0] <= pl_data;
                sp0       <= sp0 + 3'd1;
            end else if (pl_sel == 4'hE) begin
                stk1[sp1] <= pl_data;
                sp1       <= sp1 + 3'd1;
            end else begin
                regs[pl_sel] <= pl_data;
            end
        end else if (!reset) begin
            if (rf_a_rd_en) begin
                a_rd_cnt <= a_rd_cnt + 1;
                if (rf_a_sel == 4'hF) sp0 <= sp0 - 3'd1;
                else if (rf_a_sel == 4'hE) sp1 <= sp1 - 3'd1;
                else a_hold <= regs[rf_a_sel];
            end
            if (rf_b_rd_en) begin
                b_rd_cnt <= b_rd_cnt + 1;
                if (rf_b_sel == 4'hF) sp0 <= sp0 - 3'd1;
                else if (rf_b_sel == 4'hE) sp1 <= sp1 - 3'd1;
                else b_hold <= regs[rf_b_sel];
            end
            if (rf_a_wr_en) begin
                wr_cnt <= wr_cnt + 1;
                if (rf_a_sel == 4'hF) begin
                    stk0[sp0] <= rf_a_wr_data;
                    sp0       <= sp0 + 3'd1;
                end else if (rf_a_sel == 4'hE) begin
                    stk1[sp1] <= rf_a_wr_data;
                    sp1       <= sp1 + 3'd1;
                end else begin
                    regs[rf_a_sel] <= rf_a_wr_data;
                end
            end
            if (rf_a_rd_en && rf_a_wr_en) overlap_cnt <= overlap_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] sel, input logic [W-1:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_sel = sel; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Ends on the negedge of the READ cycle (cycle 1 after accept).
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] dst,
                        input logic use_b, input logic wr_back);
        @(negedge clk);
        check("req_ready_before_send", req_ready, 1'b1);
        req_a_sel = a; req_b_sel = b; req_dst_sel = dst;
        req_use_b = use_b; req_wr_back = wr_back; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_ex_valid(output int lat);
        lat = 1;
        while (ex_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Called on a WAIT-cycle negedge; returns on the negedge after the result edge.
    task automatic give_result(input logic [W-1:0] r);
        ex_result_valid = 1'b1; ex_result = r;
        @(negedge clk);
        ex_result_valid = 1'b0; ex_result = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready_valid"}, {req_ready, ex_valid}, 2'b10);
        check({tag, "_strobes"}, {rf_a_rd_en, rf_b_rd_en, rf_a_wr_en}, 3'b000);
        check({tag, "_ex_ab"}, {ex_a, ex_b}, 32'h0);
        check({tag, "_sels_wdata"}, {rf_a_sel, rf_b_sel, rf_a_wr_data}, 24'h0);
        check({tag, "_state"}, state_dbg, 3'd0);
    endtask

    initial begin
        int lat, a0, b0, w0;
        reset = 1'b1; req_valid = 1'b0; req_a_sel = 4'h0; req_b_sel = 4'h0;
        req_dst_sel = 4'h0; req_use_b = 1'b0; req_wr_back = 1'b0;
        ex_ready = 1'b0; ex_result_valid = 1'b0; ex_result = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Two general-register operands, result written to R7
        preload(4'd3, 16'h1234);
        preload(4'd5, 16'h00FF);
        ex_ready = 1'b1;
        a0 = a_rd_cnt; b0 = b_rd_cnt; w0 = wr_cnt;
        send(4'd3, 4'd5, 4'd7, 1'b1, 1'b1);
        check("t1_read_sels", {rf_a_sel, rf_b_sel}, 8'h35);
        check("t1_read_strobes", {rf_a_rd_en, rf_b_rd_en}, 2'b11);
        wait_ex_valid(lat);
        check("t1_latency", lat, 3);
        check("t1_operands", {ex_a, ex_b}, 32'h1234_00FF);
        @(negedge clk);
        check("t1_wait_no_valid", ex_valid, 1'b0);
        give_result(16'h1333);
        check("t1_write", {rf_a_wr_en, rf_a_sel, rf_a_wr_data}, {1'b1, 4'd7, 16'h1333});
        check("t1_write_no_rd", {rf_a_rd_en, rf_b_rd_en}, 2'b00);
        @(negedge clk);
        check("t1_back_idle", {req_ready, rf_a_wr_en}, 2'b10);
        check("t1_counts", {a_rd_cnt - a0, b_rd_cnt - b0, wr_cnt - w0}, {32'd1, 32'd1, 32'd0} | 96'd1);
        check("t1_r7", regs[7], 16'h1333);

        // Same-stack conflict: A pops the top, B pops the next element a cycle later
        preload(4'hF, 16'hBBBB);
        preload(4'hF, 16'hAAAA);
        a0 = a_rd_cnt; b0 = b_rd_cnt; w0 = wr_cnt;
        send(4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
        check("t2_read_pop_a_only", {rf_a_rd_en, rf_b_rd_en, rf_a_sel}, {2'b10, 4'hF});
        @(negedge clk);
        check("t2_read_b2_pop", {rf_a_rd_en, rf_b_rd_en, rf_b_sel}, {2'b01, 4'hF});
        wait_ex_valid(lat);
        check("t2_latency", lat + 1, 4);
        check("t2_operands", {ex_a, ex_b}, 32'hAAAA_BBBB);
        @(negedge clk);
        give_result(16'h0001);
        check("t2_idle_no_write", {req_ready, rf_a_wr_en}, 2'b10);
        check("t2_pop_counts", {a_rd_cnt - a0, b_rd_cnt - b0}, {32'd1, 32'd1});
        check("t2_stack_empty_no_wr", {sp0, wr_cnt - w0}, {3'd0, 32'd0});

        // Stack A with general B: no conflict, both read in one cycle
        preload(4'd2, 16'h0042);
        preload(4'hF, 16'h7777);
        send(4'hF, 4'd2, 4'h0, 1'b1, 1'b0);
        check("t3_read_sels_strobes", {rf_a_rd_en, rf_b_rd_en, rf_a_sel, rf_b_sel}, {2'b11, 4'hF, 4'd2});
        wait_ex_valid(lat);
        check("t3_latency", lat, 3);
        check("t3_operands", {ex_a, ex_b}, 32'h7777_0042);
        @(negedge clk);
        give_result(16'h0002);
        check("t3_back_idle", req_ready, 1'b1);

        // Execute stage stalls 5 cycles, result pushed onto the return stack
        preload(4'd4, 16'h2222);
        preload(4'hF, 16'h1111);
        ex_ready = 1'b0;
        w0 = wr_cnt;
        send(4'd4, 4'hF, 4'hE, 1'b1, 1'b1);
        wait_ex_valid(lat);
        check("t4_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold", {ex_valid, ex_a, ex_b}, {1'b1, 16'h2222, 16'h1111});
        end
        ex_ready = 1'b1;
        @(negedge clk);
        check("t4_wait_no_valid", ex_valid, 1'b0);
        give_result(16'h5555);
        check("t4_push", {rf_a_wr_en, rf_a_sel, rf_a_wr_data}, {1'b1, 4'hE, 16'h5555});
        @(negedge clk);
        check("t4_one_cycle_push", {rf_a_wr_en, req_ready}, 2'b01);
        check("t4_rstack", {sp1, stk1[0], wr_cnt - w0}, {3'd1, 16'h5555, 32'd1});

        // Single operand, no write-back: B port untouched, ex_b cleared
        a0 = a_rd_cnt; b0 = b_rd_cnt; w0 = wr_cnt;
        send(4'd3, 4'd5, 4'd7, 1'b0, 1'b0);
        check("t5_read_a_only", {rf_a_rd_en, rf_b_rd_en, rf_b_sel}, {2'b10, 4'h0});
        wait_ex_valid(lat);
        check("t5_latency", lat, 3);
        check("t5_operands", {ex_a, ex_b}, 32'h1234_0000);
        @(negedge clk);
        give_result(16'h4444);
        check("t5_idle_direct", {req_ready, rf_a_wr_en, state_dbg}, {2'b10, 3'd0});
        check("t5_counts", {a_rd_cnt - a0, b_rd_cnt - b0, wr_cnt - w0}, {32'd1, 32'd0, 32'd0});

        // Reset during ISSUE, then during WRITE
        w0 = wr_cnt;
        ex_ready = 1'b0;
        send(4'd3, 4'd5, 4'd9, 1'b1, 1'b1);
        wait_ex_valid(lat);
        check("t6_latency", lat, 3);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_issue_reset");
        reset = 1'b0;
        ex_ready = 1'b1;
        send(4'd3, 4'd5, 4'd9, 1'b1, 1'b1);
        wait_ex_valid(lat);
        @(negedge clk);
        give_result(16'h9999);
        reset = 1'b1;
        #1;
        check("t6_write_suppressed", rf_a_wr_en, 1'b0);
        @(negedge clk);
        check_reset_outputs("t6_write_reset");
        reset = 1'b0;
        check("t6_no_write", {wr_cnt - w0, regs[9]}, {32'd0, 16'h0000});

        // Normal operation after reset
        send(4'd5, 4'd3, 4'h0, 1'b1, 1'b0);
        wait_ex_valid(lat);
        check("t7_latency", lat, 3);
        check("t7_operands", {ex_a, ex_b}, 32'h00FF_1234);
        @(negedge clk);
        give_result(16'h0003);
        check("t7_back_idle", req_ready, 1'b1);
        check("rd_wr_overlap", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
